// File: rtl/zmod_rx_checker.sv
// zmod_rx_checker
// ---------------------------------------------------------------------------
// Receive-side framer and payload checker for the zmod 4-lane LVDS link.
// Lane 3 of each incoming word is a one-hot sync lane whose bit position gives
// the bit slip. Once the slip has been seen LOCK_COUNT times in a row, all
// lanes are realigned by that slip and the 24-bit payload is checked for an
// incrementing count (modulo 2^24).
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   din          raw word: [31:24] sync lane, [23:0] lanes 2..0
//   din_valid    din qualifier; nothing advances while low
//   clear        synchronous clear of the statistics counters (wins over +1)
//   locked       high while the FSM is in LOCKED
//   shift        bit slip currently applied (0..7)
//   dout         realigned payload {lane2, lane1, lane0}
//   dout_valid   dout qualifier, two clocks after the accepted word
//   err_pulse    one-cycle pulse, coincident with the mismatching dout
//   err_count    payload mismatches, saturating
//   word_count   payload words checked, saturating
//   unlock_count LOCKED -> HUNT transitions, saturating
//   dbg_state_o  current FSM state (0 HUNT, 1 VERIFY, 2 LOCKED)
//
// Handshake: din is consumed on every clock where din_valid is high; there is
// no back-pressure. dout is meaningful only on clocks where dout_valid is high.
// ---------------------------------------------------------------------------
module zmod_rx_checker #(
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             locked,
  output logic [2:0]       shift,
  output logic [23:0]      dout,
  output logic             dout_valid,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] unlock_count,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(UNLOCK_COUNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(UNLOCK_COUNT - 1);

  state_t            state_q;
  logic [2:0]        shift_q;
  logic [GW-1:0]     good_q;
  logic [MW-1:0]     miss_q;
  logic [15:0]       hist_q [3];
  // Stage 1: word accepted in LOCKED, waiting to be realigned and checked.
  logic              v1_q;
  logic              ok1_q;
  logic              seed_q;
  logic [23:0]       exp_q;
  logic [23:0]       dout_q;
  logic              dout_valid_q;
  logic              err_pulse_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [CNT_W-1:0]  unlock_cnt_q;

  logic [7:0]        sync_byte;
  logic              sync_onehot;
  logic [2:0]        sync_idx;
  logic              sync_match;
  logic [15:0]       win [3];
  logic [23:0]       aligned_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    sync_byte   = din[31:24];
    sync_onehot = (sync_byte != 8'd0) && ((sync_byte & (sync_byte - 8'd1)) == 8'd0);
    sync_idx    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (sync_byte[i]) sync_idx = 3'(i);
    end
    sync_match  = (sync_byte == (8'd1 << shift_q));
  end

  // Realignment window: the newest byte sits in the low half of each history,
  // so shifting right pulls the missing high bits from the previous byte.
  always_comb begin
    aligned_d = 24'd0;
    for (int l = 0; l < 3; l++) begin
      win[l] = hist_q[l] >> shift_q;
      aligned_d[l*8 +: 8] = win[l][7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      shift_q      <= 3'd0;
      good_q       <= '0;
      miss_q       <= '0;
      for (int l = 0; l < 3; l++) hist_q[l] <= 16'd0;
      v1_q         <= 1'b0;
      ok1_q        <= 1'b0;
      seed_q       <= 1'b0;
      exp_q        <= 24'd0;
      dout_q       <= 24'd0;
      dout_valid_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_cnt_q    <= '0;
      word_cnt_q   <= '0;
      unlock_cnt_q <= '0;
    end else begin
      err_pulse_q  <= 1'b0;
      dout_valid_q <= v1_q;
      v1_q         <= 1'b0;

      // Output stage and payload check for the word accepted last time.
      if (v1_q) begin
        dout_q <= aligned_d;
        if (seed_q) begin
          exp_q  <= aligned_d + 24'd1;
          seed_q <= 1'b0;
        end else if (ok1_q) begin
          word_cnt_q <= sat_inc(word_cnt_q);
          if (aligned_d != exp_q) begin
            err_cnt_q   <= sat_inc(err_cnt_q);
            err_pulse_q <= 1'b1;
            exp_q       <= aligned_d + 24'd1;
          end else begin
            exp_q <= exp_q + 24'd1;
          end
        end else begin
          // Sync-mismatched words keep the count moving but are not judged.
          exp_q <= exp_q + 24'd1;
        end
      end

      if (din_valid) begin
        for (int l = 0; l < 3; l++) hist_q[l] <= {hist_q[l][7:0], din[l*8 +: 8]};
        v1_q  <= (state_q == LOCKED);
        ok1_q <= sync_match;

        case (state_q)
          HUNT: begin
            if (sync_onehot) begin
              shift_q <= sync_idx;
              good_q  <= GW'(1);
              miss_q  <= '0;
              state_q <= VERIFY;
            end
          end
          VERIFY: begin
            if (sync_match) begin
              if (good_q == GOOD_LAST) begin
                state_q <= LOCKED;
                miss_q  <= '0;
                seed_q  <= 1'b1;
              end
              good_q <= good_q + 1'b1;
            end else begin
              state_q <= HUNT;
              good_q  <= '0;
              miss_q  <= '0;
            end
          end
          LOCKED: begin
            if (sync_match) begin
              miss_q <= '0;
            end else if (miss_q == MISS_LAST) begin
              state_q      <= HUNT;
              good_q       <= '0;
              miss_q       <= '0;
              unlock_cnt_q <= sat_inc(unlock_cnt_q);
            end else begin
              miss_q <= miss_q + 1'b1;
            end
          end
          default: begin
            state_q <= HUNT;
            good_q  <= '0;
            miss_q  <= '0;
          end
        endcase
      end

      // Placed last so a clear beats any increment in the same cycle.
      if (clear) begin
        err_cnt_q    <= '0;
        word_cnt_q   <= '0;
        unlock_cnt_q <= '0;
      end
    end
  end

  assign locked       = (state_q == LOCKED);
  assign shift        = shift_q;
  assign dout         = dout_q;
  assign dout_valid   = dout_valid_q;
  assign err_pulse    = err_pulse_q;
  assign err_count    = err_cnt_q;
  assign word_count   = word_cnt_q;
  assign unlock_count = unlock_cnt_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_zmod_rx_checker.sv
// Bench for zmod_rx_checker: a word-level reference model predicts, for every
// clock, what the DUT outputs must show; a scoreboard queue holds those
// predictions and one compare process checks them on the falling edge.
module tb_zmod_rx_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        clear;
  logic        locked;
  logic [2:0]  shift;
  logic [23:0] dout;
  logic        dout_valid;
  logic        err_pulse;
  logic [31:0] err_count;
  logic [31:0] word_count;
  logic [31:0] unlock_count;
  logic [1:0]  dbg_state;

  zmod_rx_checker #(.LOCK_COUNT(8), .UNLOCK_COUNT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .locked(locked), .shift(shift), .dout(dout), .dout_valid(dout_valid),
    .err_pulse(err_pulse), .err_count(err_count), .word_count(word_count),
    .unlock_count(unlock_count), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] due;
    logic        lk;
    logic [2:0]  sh;
    logic        dv;
    logic [23:0] d;
    logic        ep;
    logic [31:0] ec;
    logic [31:0] wc;
    logic [31:0] uc;
  } rec_t;
  rec_t exp_q[$];
  rec_t cmp_r;

  int          m_state;        // 0 hunt, 1 verify, 2 locked
  int          m_shift, m_good, m_miss;
  logic [31:0] m_prev;         // previous accepted raw word
  logic        m_pv, m_pok, m_seed;
  logic [23:0] m_pd, m_exp, m_dout;
  logic [31:0] m_ec, m_wc, m_uc;

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_shift = 0; m_good = 0; m_miss = 0; m_prev = 0;
    m_pv = 0; m_pok = 0; m_seed = 0; m_pd = 0; m_exp = 0; m_dout = 0;
    m_ec = 0; m_wc = 0; m_uc = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] w, input logic clr);
    rec_t        r;
    logic [15:0] pair;
    logic [7:0]  sb;
    logic [23:0] al;
    logic        ok;
    int          ones, k;
    r = '0;
    // payload stage for the word accepted one clock earlier
    r.dv = m_pv;
    if (m_pv) begin
      m_dout = m_pd;
      if (m_seed) begin
        m_exp = m_pd + 24'd1; m_seed = 0;
      end else if (m_pok) begin
        m_wc = sat(m_wc);
        if (m_pd != m_exp) begin
          m_ec = sat(m_ec); r.ep = 1; m_exp = m_pd + 24'd1;
        end else m_exp = m_exp + 24'd1;
      end else m_exp = m_exp + 24'd1;
    end
    m_pv = 0;
    if (v) begin
      for (int l = 0; l < 3; l++) begin
        pair = {m_prev[l*8 +: 8], w[l*8 +: 8]} >> m_shift;
        al[l*8 +: 8] = pair[7:0];
      end
      m_prev = w;
      sb = w[31:24];
      ok = (sb == (8'd1 << m_shift));
      ones = 0; k = 0;
      for (int i = 0; i < 8; i++) if (sb[i]) begin ones++; k = i; end
      m_pv = (m_state == 2); m_pd = al; m_pok = ok;
      if (m_state == 0) begin
        if (ones == 1) begin m_shift = k; m_good = 1; m_state = 1; end
      end else if (m_state == 1) begin
        if (ok) begin
          m_good++;
          if (m_good == 8) begin m_state = 2; m_miss = 0; m_seed = 1; end
        end else begin m_state = 0; m_good = 0; m_miss = 0; end
      end else begin
        if (ok) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == 4) begin m_state = 0; m_miss = 0; m_good = 0; m_uc = sat(m_uc); end
        end
      end
    end
    if (clr) begin m_ec = 0; m_wc = 0; m_uc = 0; end
    r.due = 32'(cyc + 1);
    r.lk = (m_state == 2); r.sh = 3'(m_shift); r.d = m_dout;
    r.ec = m_ec; r.wc = m_wc; r.uc = m_uc;
    exp_q.push_back(r);
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (err_pulse) pulses++;
      while (exp_q.size() > 0 && exp_q[0].due < 32'(cyc)) begin
        cmp_r = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL sched: prediction for cycle %0d not checked, now %0d", cmp_r.due, cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].due == 32'(cyc)) begin
        cmp_r = exp_q.pop_front();
        chk("locked", locked, cmp_r.lk);
        chk("shift", shift, cmp_r.sh);
        chk("dout_valid", dout_valid, cmp_r.dv);
        if (cmp_r.dv) chk("dout", dout, cmp_r.d);
        chk("err_pulse", err_pulse, cmp_r.ep);
        chk("err_count", err_count, cmp_r.ec);
        chk("word_count", word_count, cmp_r.wc);
        chk("unlock_count", unlock_count, cmp_r.uc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic v, input logic [31:0] w, input logic clr);
    din_valid = v; din = w; clear = clr;
    model_step(v, w, clr);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] aligned_word(input logic [23:0] p0, input int i,
                                               input int corrupt, input int bad_from,
                                               input int bad_n);
    logic [23:0] p;
    logic [7:0]  s;
    p = (i == corrupt) ? 24'hABCDEF : p0 + 24'(i);
    s = (i >= bad_from && i < bad_from + bad_n) ? 8'h00 : 8'h01;
    return {s, p};
  endfunction

  // Emits n words whose realigned content (after slip s) is the sequence
  // starting at p0; raw word i carries the tail of word i and head of i+1.
  task automatic stream(input logic [23:0] p0, input int n, input int s, input int gap,
                        input int corrupt, input int bad_from, input int bad_n,
                        input int clr_idx);
    logic [31:0] a_cur, a_nxt, raw;
    logic [15:0] pair;
    for (int i = 0; i < n; i++) begin
      a_cur = aligned_word(p0, i, corrupt, bad_from, bad_n);
      a_nxt = aligned_word(p0, i + 1, corrupt, bad_from, bad_n);
      for (int l = 0; l < 4; l++) begin
        pair = {a_cur[l*8 +: 8], a_nxt[l*8 +: 8]} >> (8 - s);
        raw[l*8 +: 8] = pair[7:0];
      end
      if (gap == 1 && $urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) send(1'b0, $urandom, 1'b0);
      if (gap == 2 && i > 0) send(1'b0, $urandom, 1'b0);
      send(1'b1, raw, i == clr_idx);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 32'd0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  int p_snap;
  logic [7:0] nsb;

  initial begin
    rst = 1'b1; din = 32'd0; din_valid = 1'b0; clear = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_counts", err_count | word_count | unlock_count, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // aligned stream 0..999
    stream(24'd0, 7, 0, 0, -1, -1, 0, -1);
    chk("lock_after_7", locked, 0);
    stream(24'd7, 1, 0, 0, -1, -1, 0, -1);
    chk("lock_after_8", locked, 1);
    chk("lock_shift0", shift, 0);
    stream(24'd8, 992, 0, 0, -1, -1, 0, -1);
    idle(2);
    chk("aligned_err", err_count, 0);
    chk("aligned_words", word_count, 991);

    // 3-bit slip
    send(1'b0, 32'd0, 1'b1);
    stream(24'h001000, 40, 3, 0, -1, -1, 0, -1);
    idle(2);
    chk("slip_shift", shift, 3);
    chk("slip_locked", locked, 1);
    chk("slip_err", err_count, 0);
    chk("slip_unlock", unlock_count, 1);

    // bad sync runs
    stream(24'h002000, 20, 0, 0, -1, -1, 0, -1);
    send(1'b0, 32'd0, 1'b1);
    stream(24'h002014, 20, 0, 0, -1, 5, 3, -1);
    chk("bad3_locked", locked, 1);
    chk("bad3_unlock", unlock_count, 0);
    stream(24'h002028, 9, 0, 0, -1, 5, 4, -1);
    chk("bad4_locked", locked, 0);
    chk("bad4_unlock", unlock_count, 1);
    stream(24'h002031, 7, 0, 0, -1, -1, 0, -1);
    chk("relock_7", locked, 0);
    stream(24'h002038, 1, 0, 0, -1, -1, 0, -1);
    chk("relock_8", locked, 1);

    // single corrupted payload word
    stream(24'h000100, 16, 0, 0, -1, -1, 0, -1);
    idle(2);
    send(1'b0, 32'd0, 1'b1);
    p_snap = pulses;
    stream(24'h000110, 40, 0, 0, 'h13, -1, 0, -1);
    idle(2);
    chk("corrupt_err", err_count, 2);
    chk("corrupt_pulses", 32'(pulses - p_snap), 2);
    chk("corrupt_locked", locked, 1);

    // wrap with din_valid toggling
    stream(24'hFFFFF0, 24, 0, 2, -1, -1, 0, 3);
    idle(2);
    chk("wrap_err", err_count, 0);
    chk("wrap_locked", locked, 1);

    // clear coincident with the resync error of a corrupted word
    stream(24'h000500, 20, 0, 0, 8, -1, 0, 10);
    idle(2);
    chk("clear_wins_err", err_count, 0);

    // async reset while locked with slip 5
    stream(24'h000700, 20, 5, 0, -1, -1, 0, -1);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_dv", dout_valid, 1);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_dv", dout_valid, 0);
    chk("arst_shift", shift, 0);
    chk("arst_counts", err_count | word_count | unlock_count, 0);
    model_reset();
    din_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    stream(24'h000900, 12, 2, 0, -1, -1, 0, -1);
    chk("rst_relock", locked, 1);
    chk("rst_relock_shift", shift, 2);

    // randomized segments with noise between them
    repeat (6) begin
      for (int j = 0; j < 20; j++) begin
        nsb = ($urandom_range(0, 1) == 1) ? (8'd1 << $urandom_range(0, 7)) : 8'($urandom);
        send($urandom_range(0, 3) != 0, {nsb, 24'($urandom)}, 1'b0);
      end
      begin
        int n, c;
        n = $urandom_range(20, 60);
        c = ($urandom_range(0, 1) == 1) ? $urandom_range(15, n - 1) : -1;
        stream(24'($urandom), n, $urandom_range(0, 7), $urandom_range(0, 1), c, -1, 0,
               $urandom_range(0, n + 20));
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
